wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous and active-low (asserted at 0).
REQ-003 SHALL have port mem_wreg, input, 1: the MEM-stage instruction writes a register.
REQ-004 SHALL have port mem_m2reg, input, 1: result source; 1 = memory data, 0 = ALU result.
REQ-005 SHALL have port mem_destR, input, 5: destination register address.
REQ-006 SHALL have port mem_aluR, input, 32: ALU result.
REQ-007 SHALL have port mem_mdata, input, 32: data-memory read data.
REQ-008 SHALL have port mem_valid, input, 1: the MEM-stage slot holds a real instruction.
REQ-009 SHALL have port wb_stall, input, 1: hold the WB register contents.
REQ-010 SHALL have port wb_flush, input, 1: invalidate the WB slot.
REQ-011 SHALL have ports MEM_ins_type and MEM_ins_number, input, 4 each: debug tags.
REQ-012 SHALL have port wb_destR, output, 5: register-file write address.
REQ-013 SHALL have port wb_dest, output, 32: register-file write data.
REQ-014 SHALL have port wb_wreg, output, 1: register-file write enable.
REQ-015 SHALL have port wb_valid, output, 1: the WB slot holds a real instruction.
REQ-016 SHALL have ports WB_ins_type and WB_ins_number, output, 4 each: debug tags.
REQ-017 SHALL have port retire_cnt, output, 32: retired-instruction count (see REQ-030).

Function
REQ-018 SHALL capture all mem_* and MEM_* inputs into the WB register on the rising edge, giving 1-cycle latency MEM->WB.
REQ-019 SHALL select the source at capture: wb_dest = mem_m2reg ? mem_mdata : mem_aluR; the selected value is stored, not recomputed.
REQ-020 SHALL drive wb_wreg = wb_valid & stored wreg & (wb_destR != 0); no write is ever issued to register 0.
REQ-021 SHALL hold all WB registers unchanged while wb_stall=1 and wb_flush=0.
REQ-022 SHALL clear wb_valid on a wb_flush=1 edge; the other fields are don't-care but wb_wreg SHALL be 0 the next cycle.
REQ-023 SHALL give wb_flush priority over wb_stall when both are 1.
REQ-024 SHALL capture mem_valid=0 as a bubble: wb_valid=0, wb_wreg=0.
REQ-025 SHALL retire an instruction in each cycle with wb_valid=1 and wb_stall=0; a stalled instruction is retired exactly once.
REQ-026 SHALL make all outputs purely registered, or the registered term ANDed per REQ-020, with no combinational path from any input to any output.

Reset
REQ-027 SHALL, while rst=0, immediately force wb_valid=0, wb_wreg=0, wb_destR=0, wb_dest=0, WB_ins_type=0, WB_ins_number=0, retire_cnt=0.
REQ-028 SHALL, on a reset asserted mid-stall, discard the held instruction, which is never retired.
REQ-029 SHALL capture normally on the first rising edge after rst returns to 1.

Configuration
REQ-030 SHALL implement the retirement counter when macro WB_RETIRE_CNT_EN is defined: it increments by 1 per REQ-025 and wraps from 32'hFFFFFFFF to 0.
REQ-031 SHALL, without WB_RETIRE_CNT_EN, tie retire_cnt to 32'h0 and instantiate no counter flops.

Verification
REQ-032 SHALL be verified for ALU writeback: mem_valid=1, wreg=1, m2reg=0, destR=5, aluR=32'h1234 -> next cycle wb_wreg=1, wb_destR=5, wb_dest=32'h1234.
REQ-033 SHALL be verified for load writeback: m2reg=1, mdata=32'hDEADBEEF, aluR=32'h10, destR=8 -> wb_dest=32'hDEADBEEF, wb_destR=8.
REQ-034 SHALL be verified for register 0: wreg=1, destR=0 -> wb_wreg=0, wb_valid=1, retire_cnt+1.
REQ-035 SHALL be verified for stall: instruction captured, then wb_stall=1 for 3 cycles with changing inputs -> outputs held, retire_cnt increments exactly once.
REQ-036 SHALL be verified for flush over stall: wb_stall=1 and wb_flush=1 together -> next cycle wb_valid=0, wb_wreg=0.
REQ-037 SHALL be verified for wrap and reset: counter preloaded to 32'hFFFFFFFF, one retirement -> 0; rst=0 mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: MEM->WB pipeline register with writeback source select at capture.
// Optional retirement counter is built only when WB_RETIRE_CNT_EN is defined.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wreg,
  input  logic        mem_m2reg,
  input  logic [4:0]  mem_destR,
  input  logic [31:0] mem_aluR,
  input  logic [31:0] mem_mdata,
  input  logic        mem_valid,
  input  logic        wb_stall,
  input  logic        wb_flush,
  input  logic [3:0]  MEM_ins_type,
  input  logic [3:0]  MEM_ins_number,
  output logic [4:0]  wb_destR,
  output logic [31:0] wb_dest,
  output logic        wb_wreg,
  output logic        wb_valid,
  output logic [3:0]  WB_ins_type,
  output logic [3:0]  WB_ins_number,
  output logic [31:0] retire_cnt
);

  logic        valid_q, valid_d;
  logic        wreg_q, wreg_d;
  logic [4:0]  dest_r_q, dest_r_d;
  logic [31:0] dest_q, dest_d;
  logic [3:0]  ins_type_q, ins_type_d;
  logic [3:0]  ins_num_q, ins_num_d;

  // Flush wins over stall; flushed payload fields are simply left as they were.
  always_comb begin
    valid_d    = valid_q;
    wreg_d     = wreg_q;
    dest_r_d   = dest_r_q;
    dest_d     = dest_q;
    ins_type_d = ins_type_q;
    ins_num_d  = ins_num_q;
    if (wb_flush) begin
      valid_d = 1'b0;
    end else if (!wb_stall) begin
      valid_d    = mem_valid;
      wreg_d     = mem_wreg;
      dest_r_d   = mem_destR;
      dest_d     = mem_m2reg ? mem_mdata : mem_aluR;
      ins_type_d = MEM_ins_type;
      ins_num_d  = MEM_ins_number;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      wreg_q     <= 1'b0;
      dest_r_q   <= 5'd0;
      dest_q     <= 32'd0;
      ins_type_q <= 4'd0;
      ins_num_q  <= 4'd0;
    end else begin
      valid_q    <= valid_d;
      wreg_q     <= wreg_d;
      dest_r_q   <= dest_r_d;
      dest_q     <= dest_d;
      ins_type_q <= ins_type_d;
      ins_num_q  <= ins_num_d;
    end
  end

  assign wb_valid      = valid_q;
  assign wb_wreg       = valid_q & wreg_q & (dest_r_q != 5'd0);
  assign wb_destR      = dest_r_q;
  assign wb_dest       = dest_q;
  assign WB_ins_type   = ins_type_q;
  assign WB_ins_number = ins_num_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  // A stalled instruction only retires in the cycle its stall is released.
  assign retire_cnt_d = (valid_q && !wb_stall) ? retire_cnt_q + 32'd1 : retire_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) retire_cnt_q <= 32'd0;
    else      retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`else
  assign retire_cnt = 32'h0;
`endif

endmodule
